pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch-sequencing stage for the CPU. It generates the instruction address presented to the instruction ROM and hands each address to the decode stage over a valid/ready handshake. It sits directly downstream of the combinational control logic (the or2/and2/mux gate layer), which drives its `load_en`/`hold` controls. Jumps retarget the counter and insert a one-cycle bubble to cover ROM read latency.

## Interface
- `WIDTH`, 16, counter/address width in bits (≥2)
- `RESET_VECTOR`, 0, address loaded on reset (must fit in `WIDTH`)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_en`  in  1  jump request: retarget counter to `load_addr`
- `load_addr`  in  WIDTH  jump target
- `hold`  in  1  freeze counter and state (load still honoured)
- `pc`  out  WIDTH  current fetch address
- `out_valid`  out  1  `pc` is a valid fetch for decode
- `out_ready`  in  1  decode accepts `pc` this cycle
- `wrapped`  out  1  sticky: counter has wrapped from all-ones to zero

## Operation
- States: BOOT, RUN, BUBBLE (2-bit encoding, BOOT=0).
- Reset (async assert, any time, including mid-transfer): state=BOOT, `pc`=RESET_VECTOR, `out_valid`=0, `wrapped`=0. Release is sampled on the next rising edge.
- BOOT: `out_valid`=0. Next cycle → RUN (unless `hold`=1 and `load_en`=0, then stay).
- RUN: `out_valid`=1. Transfer = `out_valid & out_ready`.
  - Transfer, no load, no hold: `pc` ← `pc`+1 mod 2^WIDTH. If `pc` was all-ones, set `wrapped`.
  - No transfer: `pc` unchanged; `out_valid` stays 1 (no retraction).
- BUBBLE: `out_valid`=0. Next cycle → RUN (unless held).
- `load_en`=1 in any non-reset state: `pc` ← `load_addr`, state ← BUBBLE, `wrapped` ← 0. This overrides increment and `hold`. A transfer in the same cycle is still counted as consumed by decode; the increment is discarded.
- `hold`=1 with `load_en`=0: `pc`, state and `wrapped` frozen. `out_valid` keeps its state-derived value, so decode may still see valid=1 but the transfer is not counted and does not advance.
- Priority: `rst` > `load_en` > `hold` > increment.
- Address arithmetic is unsigned, WIDTH bits, with no carry out. Only `wrapped` records overflow.

## Timing
- All state updates occur on the rising edge of `clk`. Outputs are registered/state-decoded, with no combinational path from `out_ready`, `load_en` or `hold` to any output.
- First valid address: 1 cycle after reset release (BOOT).
- Jump latency: `load_en` at edge N, `pc`=`load_addr` after N, `out_valid`=0 for cycle N..N+1, valid again after edge N+1.
- Sustained throughput: 1 address/cycle with `out_ready`=1.
- `wrapped` updates on the same edge as the wrapping increment.

## Test plan
- Reset/boot: assert `rst` mid-cycle with `pc`=0x0042 → `pc`=0x0000, `out_valid`=0 immediately. Release → 1 bubble cycle, then `out_valid`=1, `pc`=0x0000.
- Stream: `out_ready`=1 for 4 cycles after boot → decode sees 0x0000, 0x0001, 0x0002, 0x0003 on consecutive cycles.
- Backpressure: `out_ready`=0 for 3 cycles at `pc`=0x0005 → `pc` holds 0x0005 and `out_valid` stays 1. Raise ready → next address is 0x0006.
- Jump: `load_en`=1, `load_addr`=0x1234, with a simultaneous transfer at 0x0007 → next cycle `pc`=0x1234, `out_valid`=0. The following cycle `out_valid`=1 at 0x1234; 0x0008 is never presented.
- Hold vs load: `hold`=1 for 2 cycles → `pc` is frozen. `hold`=1 with `load_en`=1, `load_addr`=0x00FF → `pc`=0x00FF and state BUBBLE.
- Wrap: load 0xFFFE, stream 2 transfers → `pc` goes 0xFFFE, 0xFFFF, 0x0000 and `wrapped`=1. A subsequent load of 0x0010 → `wrapped`=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: presents instruction addresses to decode
// over a valid/ready handshake, with a one-cycle bubble after boot and each jump.
module pc_fetch #(
  parameter int unsigned          WIDTH        = 16,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             hold,
  output logic [WIDTH-1:0] pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrapped
);

  localparam logic [1:0] StBoot   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StBubble = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrapped_q, wrapped_d;
  logic             valid;
  logic             transfer;

  // Valid is decoded from state only, so no input reaches an output combinationally.
  assign valid    = (state_q == StRun);
  assign transfer = valid & out_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
    if (load_en) begin
      // A same-cycle transfer is consumed by decode; its increment is dropped.
      pc_d      = load_addr;
      state_d   = StBubble;
      wrapped_d = 1'b0;
    end else if (!hold) begin
      case (state_q)
        StBoot:   state_d = StRun;
        StBubble: state_d = StRun;
        StRun: begin
          if (transfer) begin
            pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
            if (&pc_q) wrapped_d = 1'b1;
          end
        end
        default:  state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VECTOR;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign pc        = pc_q;
  assign out_valid = valid;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed test-plan sequence with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pc_fetch;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_addr = '0;
  logic         hold = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] pc;
  logic         out_valid;
  logic         wrapped;

  int checks = 0;
  int errors = 0;

  pc_fetch #(.WIDTH(W), .RESET_VECTOR(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .hold      (hold),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  // Model: address, whether we still owe a bubble cycle, and the overflow flag.
  logic [W-1:0] m_pc = '0;
  logic         m_waiting = 1'b1;
  logic         m_wrapped = 1'b0;
  logic [W:0]   m_sum;

  assign m_sum = {1'b0, m_pc} + 17'd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc      <= 16'h0000;
      m_waiting <= 1'b1;
      m_wrapped <= 1'b0;
    end else if (load_en) begin
      m_pc      <= load_addr;
      m_waiting <= 1'b1;
      m_wrapped <= 1'b0;
    end else if (hold) begin
      m_pc <= m_pc;
    end else if (m_waiting) begin
      m_waiting <= 1'b0;
    end else if (out_ready) begin
      m_pc <= m_sum[W-1:0];
      if (m_sum[W]) m_wrapped <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " pc"},      {16'h0, pc},           {16'h0, m_pc});
    check({tag, " valid"},   {31'h0, out_valid},    {31'h0, !m_waiting});
    check({tag, " wrapped"}, {31'h0, wrapped},      {31'h0, m_wrapped});
  endtask

  // Drive inputs just after a falling edge, confirm outputs did not react
  // combinationally, clock once, and compare at the next falling edge.
  task automatic step(input logic r, input logic ld, input logic [W-1:0] a,
                      input logic h, input logic rdy);
    rst = r; load_en = ld; load_addr = a; hold = h; out_ready = rdy;
    #1;
    cmp_model("pre");
    @(posedge clk);
    @(negedge clk);
    cmp_model("post");
  endtask

  task automatic lit(input string name, input logic [W-1:0] exp_pc, input logic exp_v);
    check({name, " pc"},    {16'h0, pc},        {16'h0, exp_pc});
    check({name, " valid"}, {31'h0, out_valid}, {31'h0, exp_v});
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    cmp_model("init");
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);      // BOOT -> RUN
    step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    lit("pre_reset", 16'h0042, 1'b1);

    // Mid-cycle asynchronous reset.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    lit("async_rst", 16'h0000, 1'b0);
    check("async_rst wrapped", {31'h0, wrapped}, 32'h0);
    @(negedge clk);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    lit("boot_done", 16'h0000, 1'b1);

    // Stream four addresses.
    for (int i = 0; i < 4; i++) begin
      lit("stream", 16'(i), 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      lit("backpressure", 16'h0005, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("after_bp", 16'h0006, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("pre_jump", 16'h0007, 1'b1);

    // Jump with simultaneous transfer at 0x0007.
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
    lit("jump_bubble", 16'h1234, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("jump_target", 16'h1234, 1'b1);

    // Hold, then hold overridden by load.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    lit("hold", 16'h1234, 1'b1);
    step(1'b0, 1'b1, 16'h00FF, 1'b1, 1'b1);
    lit("hold_load", 16'h00FF, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    lit("held_bubble", 16'h00FF, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("bubble_release", 16'h00FF, 1'b1);

    // Wrap and clear.
    step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    lit("wrap0", 16'hFFFE, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("wrap1", 16'hFFFF, 1'b1);
    check("wrap1 wrapped", {31'h0, wrapped}, 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    lit("wrap2", 16'h0000, 1'b1);
    check("wrap2 wrapped", {31'h0, wrapped}, 32'h1);
    step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1);
    check("wrap_clear", {31'h0, wrapped}, 32'h0);

    // Random traffic; loads often land near the top to exercise wrapping.
    for (int i = 0; i < 3000; i++) begin
      logic         r, ld, h, rdy;
      logic [W-1:0] a;
      r   = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      h   = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 1) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                        : 16'($urandom);
      step(r, ld, a, h, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
